// File: rtl/ifu_fetch_bridge_if.sv
// Fetch-side handshake between the IFU, the fetch bridge and the memory port.
// The bridge uses the slave modport; the IFU/memory side uses master.
interface ifu_fetch_bridge_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LINE_W = 128
);
    logic              pc_index_valid;
    logic [ADDR_W-1:0] pc_index;
    logic              pc_index_ready;
    logic              pc_operation_done;
    logic [LINE_W-1:0] pc_read_inst;
    logic              redirect_valid;
    logic              bus_grant;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_resp_data;

    modport slave (
        input  pc_index_valid, pc_index, redirect_valid, bus_grant,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output pc_index_ready, pc_operation_done, pc_read_inst,
        output mem_req_valid, mem_req_addr
    );

    modport master (
        output pc_index_valid, pc_index, redirect_valid, bus_grant,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  pc_index_ready, pc_operation_done, pc_read_inst,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/ifu_fetch_bridge.sv
// Single-outstanding fetch bridge: turns an IFU PC request into a line read and
// returns the line, discarding responses that belong to a redirected fetch.
module ifu_fetch_bridge #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned OFF_W  = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    ifu_fetch_bridge_if.slave bus,
    output logic              fetch_busy,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrop} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              req_valid;
    logic              idx_ready;
    logic              op_done;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        line_d      = line_q;
        fetch_cnt_d = fetch_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        req_valid   = 1'b0;
        idx_ready   = 1'b0;
        op_done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.pc_index_valid && !bus.redirect_valid) begin
                    addr_d  = bus.pc_index & AlignMask;
                    state_d = StReq;
                end
            end
            StReq: begin
                req_valid = bus.bus_grant;
                if (req_valid && bus.mem_req_ready) begin
                    idx_ready = 1'b1;
                    // Accepted but already stale: the response must still be absorbed.
                    state_d   = bus.redirect_valid ? StDrop : StWait;
                end else if (bus.redirect_valid) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (bus.mem_resp_valid) begin
                    if (bus.redirect_valid) begin
                        drop_cnt_d = drop_cnt_q + 1'b1;
                        state_d    = StIdle;
                    end else begin
                        line_d  = bus.mem_resp_data;
                        state_d = StDone;
                    end
                end else if (bus.redirect_valid) begin
                    state_d = StDrop;
                end
            end
            StDone: begin
                op_done     = 1'b1;
                fetch_cnt_d = fetch_cnt_q + 1'b1;
                state_d     = StIdle;
            end
            StDrop: begin
                if (bus.mem_resp_valid) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            line_q      <= '0;
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            fetch_cnt_q <= fetch_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.mem_req_valid     = req_valid;
    assign bus.mem_req_addr      = addr_q;
    assign bus.pc_index_ready    = idx_ready;
    assign bus.pc_operation_done = op_done;
    assign bus.pc_read_inst      = line_q;
    assign fetch_busy            = (state_q != StIdle);
    assign fetch_cnt             = fetch_cnt_q;
    assign drop_cnt              = drop_cnt_q;
endmodule

// File: tb/tb_ifu_fetch_bridge.sv
// Directed bench for ifu_fetch_bridge; a scoreboard monitor pops expected
// addresses/lines whenever the bridge pulses pc_index_ready / pc_operation_done.
module tb_ifu_fetch_bridge;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_busy;
    logic [31:0] fetch_cnt;
    logic [31:0] drop_cnt;

    ifu_fetch_bridge_if #(.ADDR_W(64), .LINE_W(128)) bus ();

    ifu_fetch_bridge #(
        .ADDR_W(64), .LINE_W(128), .OFF_W(4), .CNT_W(32)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .fetch_busy (fetch_busy),
        .fetch_cnt  (fetch_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clock = ~clock;

    int unsigned   n_cmp  = 0;
    int unsigned   n_fail = 0;
    logic [63:0]   exp_addr_q[$];
    logic [127:0]  exp_line_q[$];

    localparam logic [127:0] LineA5 = {16{8'hA5}};
    localparam logic [127:0] LineB  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] LineC3 = {16{8'hC3}};
    localparam logic [127:0] LineDd = {4{32'hDEADBEEF}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Presents a request in IDLE for one cycle; returns with the bridge in REQ.
    task automatic issue(input logic [63:0] pc);
        bus.pc_index_valid = 1'b1;
        bus.pc_index       = pc;
        step(1);
        bus.pc_index_valid = 1'b0;
    endtask

    task automatic respond(input logic [127:0] data);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data;
        step(1);
        bus.mem_resp_valid = 1'b0;
    endtask

    initial begin
        reset_n            = 1'b0;
        bus.pc_index_valid = 1'b0;
        bus.pc_index       = '0;
        bus.redirect_valid = 1'b0;
        bus.bus_grant      = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;

        fork
            forever begin
                @(negedge clock);
                if (reset_n) begin
                    if (bus.pc_index_ready) begin
                        n_cmp++;
                        if (exp_addr_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_pc_index_ready: got 1 expected 0 at %0t", $time);
                        end else begin
                            check("req_addr", 128'(bus.mem_req_addr), 128'(exp_addr_q.pop_front()));
                        end
                    end
                    if (bus.pc_operation_done) begin
                        n_cmp++;
                        if (exp_line_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
                        end else begin
                            check("read_inst", bus.pc_read_inst, exp_line_q.pop_front());
                        end
                    end
                end
            end
        join_none

        step(2);
        check("rst_busy", 128'(fetch_busy), 128'(0));
        check("rst_req_valid", 128'(bus.mem_req_valid), 128'(0));
        check("rst_addr", 128'(bus.mem_req_addr), 128'(0));
        check("rst_inst", bus.pc_read_inst, 128'(0));
        check("rst_fetch_cnt", 128'(fetch_cnt), 128'(0));
        reset_n = 1'b1;
        step(1);

        // Basic fetch, minimum latency.
        bus.bus_grant     = 1'b1;
        bus.mem_req_ready = 1'b1;
        exp_addr_q.push_back(64'h8000_0000);
        issue(64'h8000_000C);
        check("basic_req_valid", 128'(bus.mem_req_valid), 128'(1));
        step(1);
        check("wait_req_valid", 128'(bus.mem_req_valid), 128'(0));
        exp_line_q.push_back(LineA5);
        respond(LineA5);
        check("done_busy", 128'(fetch_busy), 128'(1));
        step(1);
        check("basic_fetch_cnt", 128'(fetch_cnt), 128'(1));
        check("basic_idle", 128'(fetch_busy), 128'(0));

        // Grant stall: request held invisible and address stable.
        bus.bus_grant = 1'b0;
        issue(64'h1234_5678_9ABC_DEF7);
        for (int i = 0; i < 5; i++) begin
            check("stall_req_valid", 128'(bus.mem_req_valid), 128'(0));
            check("stall_addr", 128'(bus.mem_req_addr), 128'(64'h1234_5678_9ABC_DEF0));
            step(1);
        end
        exp_addr_q.push_back(64'h1234_5678_9ABC_DEF0);
        bus.bus_grant = 1'b1;
        step(1);
        exp_line_q.push_back(LineB);
        respond(LineB);
        step(1);
        check("stall_fetch_cnt", 128'(fetch_cnt), 128'(2));

        // Redirect two cycles after acceptance, response three cycles later.
        exp_addr_q.push_back(64'h4000_0010);
        issue(64'h4000_0010);
        step(2);
        bus.redirect_valid = 1'b1;
        step(1);
        bus.redirect_valid = 1'b0;
        check("drop_busy", 128'(fetch_busy), 128'(1));
        step(2);
        respond(LineDd);
        check("drop_cnt_1", 128'(drop_cnt), 128'(1));
        check("drop_inst_kept", bus.pc_read_inst, LineB);
        check("drop_idle", 128'(fetch_busy), 128'(0));

        // Redirect coincident with response in WAIT, then a clean fetch.
        exp_addr_q.push_back(64'h4000_0020);
        issue(64'h4000_0020);
        step(1);
        bus.redirect_valid = 1'b1;
        respond(LineDd);
        bus.redirect_valid = 1'b0;
        check("coinc_idle", 128'(fetch_busy), 128'(0));
        check("coinc_drop_cnt", 128'(drop_cnt), 128'(2));
        check("coinc_inst_kept", bus.pc_read_inst, LineB);
        exp_addr_q.push_back(64'h5555_5555_5555_5550);
        issue(64'h5555_5555_5555_5558);
        step(1);
        exp_line_q.push_back(LineC3);
        respond(LineC3);
        step(1);
        check("coinc_fetch_cnt", 128'(fetch_cnt), 128'(3));

        // Redirect in REQ before acceptance withdraws the request.
        bus.mem_req_ready = 1'b0;
        issue(64'h6000_0000);
        check("req_pending", 128'(bus.mem_req_valid), 128'(1));
        bus.redirect_valid = 1'b1;
        step(1);
        bus.redirect_valid = 1'b0;
        check("withdraw_idle", 128'(fetch_busy), 128'(0));
        check("withdraw_req_valid", 128'(bus.mem_req_valid), 128'(0));
        check("withdraw_drop_cnt", 128'(drop_cnt), 128'(2));

        // Request with coincident redirect in IDLE is ignored; stray response too.
        bus.redirect_valid = 1'b1;
        issue(64'h6000_0100);
        bus.redirect_valid = 1'b0;
        check("ignored_idle", 128'(fetch_busy), 128'(0));
        respond(LineDd);
        check("stray_drop_cnt", 128'(drop_cnt), 128'(2));
        check("stray_fetch_cnt", 128'(fetch_cnt), 128'(3));

        // Reset in WAIT; late response must be ignored.
        bus.mem_req_ready = 1'b1;
        exp_addr_q.push_back(64'h7000_0040);
        issue(64'h7000_0040);
        step(1);
        reset_n = 1'b0;
        #2;
        check("arst_busy", 128'(fetch_busy), 128'(0));
        check("arst_inst", bus.pc_read_inst, 128'(0));
        step(1);
        reset_n = 1'b1;
        respond(LineDd);
        step(1);
        check("post_rst_fetch_cnt", 128'(fetch_cnt), 128'(0));
        check("post_rst_drop_cnt", 128'(drop_cnt), 128'(0));
        check("post_rst_inst", bus.pc_read_inst, 128'(0));
        check("post_rst_addr", 128'(bus.mem_req_addr), 128'(0));
        check("post_rst_busy", 128'(fetch_busy), 128'(0));

        check("addr_queue_drained", 128'(exp_addr_q.size()), 128'(0));
        check("line_queue_drained", 128'(exp_line_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu_fetch_bridge.md
Name: ifu_fetch_bridge

Overview:
- Sits directly upstream of the IFU top: it serves the IFU's fetch request (pc_index_valid/pc_index) by issuing a 128-bit line read to the memory/DDR port.
- Returns the line on pc_read_inst with a pc_operation_done pulse.
- Keeps at most one fetch outstanding.
- Discards stale responses after a redirect so the ibuffer never sees wrong-path data.

Parameters:
- ADDR_W, 64, width of pc_index and mem_req_addr.
- LINE_W, 128, fetch line width in bits.
- OFF_W, 4, byte-offset bits cleared when aligning the request address; equals log2(LINE_W/8).
- CNT_W, 32, width of the performance counters.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pc_index_valid  in  1  IFU fetch request
- pc_index  in  ADDR_W  fetch PC from IFU
- pc_index_ready  out  1  pulse: request accepted by memory
- pc_operation_done  out  1  pulse: pc_read_inst valid this cycle
- pc_read_inst  out  LINE_W  returned instruction line
- redirect_valid  in  1  flush of in-flight fetch
- bus_grant  in  1  memory port granted to fetch (low = LSU owns port)
- mem_req_valid  out  1  read request to memory
- mem_req_addr  out  ADDR_W  line-aligned address
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  read data returned, single-cycle
- mem_resp_data  in  LINE_W  read data
- fetch_busy  out  1  state != IDLE
- fetch_cnt  out  CNT_W  completed fetches, wraps
- drop_cnt  out  CNT_W  discarded responses, wraps

Behaviour:
- Reset values (asynchronous, reset_n=0): state=IDLE; pc_index_ready=0; pc_operation_done=0; pc_read_inst=0; mem_req_valid=0; mem_req_addr=0; counters=0.
  - Reset mid-operation: return to IDLE immediately.
  - A response arriving after reset is ignored.
- State IDLE:
  - pc_index_valid=1 and redirect_valid=0 → latch addr = {pc_index[ADDR_W-1:OFF_W], OFF_W'b0}, go to REQ.
  - pc_index_valid with redirect_valid in the same cycle → ignored, stay in IDLE.
- State REQ:
  - mem_req_valid = bus_grant.
  - mem_req_valid & mem_req_ready → pulse pc_index_ready for 1 cycle, go to WAIT.
  - redirect_valid and not accepted this cycle → withdraw request, go to IDLE, no pulses.
  - redirect_valid in the same cycle as acceptance → go to DROP.
  - bus_grant=0 → hold in REQ with mem_req_valid=0, address stable.
- State WAIT:
  - mem_resp_valid → register mem_resp_data into pc_read_inst, go to DONE.
  - redirect_valid without response → go to DROP.
  - redirect_valid with mem_resp_valid in the same cycle → discard the data, drop_cnt+1, go to IDLE.
- State DONE, one cycle:
  - pc_operation_done=1, fetch_cnt+1, return to IDLE.
  - pc_read_inst holds its value until the next DONE.
  - A redirect during DONE does not suppress the pulse; the ibuffer flushes on its own.
- State DROP:
  - Wait for mem_resp_valid, then drop_cnt+1 and go to IDLE.
  - No pc_operation_done; pc_read_inst unchanged.
  - Further redirects have no effect.
- Latency:
  - pc_index_valid accepted in cycle N → mem_req_valid in N+1.
  - Response in cycle M → pc_operation_done in M+1.
  - Minimum end-to-end latency is 3 cycles when the memory is ready and responds the cycle after acceptance.
- Invariants:
  - At most one request outstanding.
  - mem_req_valid is never asserted outside REQ.
  - pc_index_ready and pc_operation_done each pulse exactly once per completed fetch.
  - mem_resp_valid in IDLE/REQ is a protocol error: ignored, no counter change.
- Counters wrap at 2^CNT_W with no saturation.

Test Plan:
- Basic fetch: pc_index=0x8000_000C, bus_grant=1, ready immediate, resp 1 cycle later with data 0xA5…A5.
  - mem_req_addr=0x8000_0000.
  - pc_index_ready pulse.
  - pc_operation_done in the cycle after resp, pc_read_inst=0xA5…A5.
  - fetch_cnt=1.
- Grant stall: bus_grant=0 for 5 cycles in REQ → mem_req_valid=0, addr stable, no pulses; then grant=1 → normal completion.
- Redirect in WAIT: redirect 2 cycles after acceptance, resp 3 cycles later → no pc_operation_done, drop_cnt=1, pc_read_inst unchanged, back to IDLE.
- Redirect coincident with mem_resp_valid in WAIT → data discarded, drop_cnt+1, IDLE next cycle; a new pc_index_valid then completes normally.
- Redirect in REQ before mem_req_ready → request withdrawn, no pc_index_ready, drop_cnt unchanged, IDLE.
- Reset asserted in WAIT, then a resp arrives after release → all outputs 0, no done pulse, counters 0.
